// File: rtl/alu_pkg.sv
// Shared opcode and flag definitions for the shared 4-bit ALU and its arbiter.
package alu_pkg;

    localparam int unsigned OP_W  = 3;
    localparam int unsigned FLG_W = 5;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_NOT = 3'b010;
    localparam logic [OP_W-1:0] OP_AND = 3'b011;
    localparam logic [OP_W-1:0] OP_OR  = 3'b100;
    localparam logic [OP_W-1:0] OP_XOR = 3'b101;
    localparam logic [OP_W-1:0] OP_SLT = 3'b110;
    localparam logic [OP_W-1:0] OP_EQ  = 3'b111;

    localparam int unsigned FLG_OV    = 4;
    localparam int unsigned FLG_CARRY = 3;
    localparam int unsigned FLG_ZERO  = 2;
    localparam int unsigned FLG_COMP  = 1;
    localparam int unsigned FLG_EQ    = 0;

endpackage

// File: rtl/alu4_core.sv
// Purely combinational ALU: arithmetic, logic and compare ops with a 5-bit flag vector.
module alu4_core
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 4
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] result,
    output logic [FLG_W-1:0]  flags
);

    localparam int unsigned MSB = DATA_W - 1;

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // Extra top bit of sum is the carry; top bit of diff is the borrow.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        flags  = '0;
        case (op)
            OP_ADD: begin
                result           = sum[DATA_W-1:0];
                flags[FLG_CARRY] = sum[DATA_W];
                flags[FLG_OV]    = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                result           = diff[DATA_W-1:0];
                flags[FLG_CARRY] = diff[DATA_W];
                flags[FLG_OV]    = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_NOT: result = ~a;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SLT: flags[FLG_COMP] = $signed(a) < $signed(b);
            OP_EQ:  flags[FLG_EQ]   = (a == b);
            default: result = '0;
        endcase
        flags[FLG_ZERO] = (result == '0);
    end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one alu4_core between two requesters, with a single
// registered, id-tagged response slot under valid/ready backpressure.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [OP_W-1:0]   req_op0,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [OP_W-1:0]   req_op1,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic [FLG_W-1:0]  rsp_flags,
    output logic [CNT_W-1:0]  ops_done
);

    logic              last_grant;
    logic [1:0]        grant_c;
    logic              slot_free_c;
    logic              accept_c;
    logic              sel_c;
    logic [OP_W-1:0]   core_op_c;
    logic [DATA_W-1:0] core_a_c;
    logic [DATA_W-1:0] core_b_c;
    logic [DATA_W-1:0] core_result_c;
    logic [FLG_W-1:0]  core_flags_c;

    // Round-robin: a lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        grant_c = 2'b00;
        case (req_valid)
            2'b01:   grant_c = 2'b01;
            2'b10:   grant_c = 2'b10;
            2'b11:   grant_c = last_grant ? 2'b01 : 2'b10;
            default: grant_c = 2'b00;
        endcase
    end

    // Ready is held low during reset so nothing looks accepted while state clears.
    always_comb begin
        slot_free_c = !rsp_valid || rsp_ready;
        req_ready   = (slot_free_c && rst_n) ? grant_c : 2'b00;
        accept_c    = |(req_valid & req_ready);
        sel_c       = grant_c[1];
    end

    always_comb begin
        core_op_c = sel_c ? req_op1 : req_op0;
        core_a_c  = sel_c ? req_a1  : req_a0;
        core_b_c  = sel_c ? req_b1  : req_b0;
    end

    alu4_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .a      (core_a_c),
        .b      (core_b_c),
        .op     (core_op_c),
        .result (core_result_c),
        .flags  (core_flags_c)
    );

    // Response slot: a new accept overwrites a draining entry for back-to-back throughput.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            last_grant <= 1'b1;
        end else if (accept_c) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= sel_c;
            rsp_result <= core_result_c;
            rsp_flags  <= core_flags_c;
            last_grant <= sel_c;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_done <= '0;
        end else if (rsp_valid && rsp_ready) begin
            ops_done <= ops_done + CNT_W'(1);
        end
    end

endmodule
